csa_seq_adder: RTL
==================

# csa_seq_adder

Multi-cycle wide add/subtract sequencer built around a single 16-bit carry-select adder slice. It accepts two `16*WORDS`-bit operands, then feeds one 16-bit slice per cycle through the adder, LSB slice first, with the carry registered between slices. It sits in the ALU datapath wherever operands wider than 16 bits must be summed without replicating adder hardware.

## Interface
- `WORDS`, default 4: number of 16-bit slices; operand width `W = 16*WORDS`; legal range 2..16.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `start` input 1: request a new operation; sampled only while `ready`=1.
- `op_sub` input 1: 0 = A+B, 1 = A−B; sampled with `start`.
- `a` input W: operand A; sampled with `start`.
- `b` input W: operand B; sampled with `start`.
- `ready` output 1: 1 only in IDLE; new `start` accepted.
- `done` output 1: one-cycle pulse marking a valid result.
- `result` output W: sum/difference.
- `cout` output 1: carry out of the MSB slice; for subtract, 1 = no borrow.
- `overflow` output 1: two's-complement signed overflow.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: `ready`=1. `start`=1 → latch `a`, latch `b` (or `~b` if `op_sub`), carry register ← `op_sub`, slice index ← 0, go to RUN. Otherwise stay.
- RUN: the adder gets slice[idx] of A, slice[idx] of effective B, and cin = carry register.
  - Write the 16-bit sum into `result` slice[idx].
  - Carry register ← adder cout; idx ← idx+1.
  - At idx = WORDS−1, load `cout` from adder cout and compute `overflow` = (A_msb == Beff_msb) && (sum_msb != A_msb), then go to DONE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `start` outside IDLE is ignored. It is not queued. Operand changes outside IDLE have no effect.
- `result`, `cout` and `overflow` hold their values from DONE until the next accepted `start`.
  - `result` slices change during RUN and are not valid until `done`.
  - `cout` and `overflow` clear to 0 on acceptance.
- Slice index width is `$clog2(WORDS)`. The index never wraps past WORDS−1.

## Timing
- Reset values (asynchronous, immediate): state IDLE, `ready`=1, `done`=0, `result`=0, `cout`=0, `overflow`=0, carry register 0, index 0.
- Reset mid-RUN or mid-DONE aborts the operation. No `done` is produced. `ready`=1 while `rst_n` is low and after release.
- `start` accepted at edge T0 gives:
  - RUN during cycles T0+1 .. T0+WORDS;
  - `done`=1 in cycle T0+WORDS+1;
  - `ready`=1 again in cycle T0+WORDS+2.
- Total latency is WORDS+1 cycles from the accept edge to `done`. Issue interval is WORDS+2 cycles.
- The adder path is combinational within one cycle. The only cross-slice path is the registered carry.

## Structure
- Shared package `alu_pkg`:
  - `SLICE_W = 16`;
  - the state enum `seq_state_t` {IDLE, RUN, DONE}.
- One sub-module instance: `CSA16`, the existing 16-bit carry-select adder, used as the slice datapath.
- Slice mux/demux and the FSM live in this module. Operands go in registers; B is inverted at latch time for subtract.

## Test plan
All cases use WORDS=4.
- Carry across slices: `a`=0x0000_0000_0000_FFFF, `b`=1, add → `result`=0x0000_0000_0001_0000, `cout`=0, `overflow`=0, `done` exactly 5 cycles after the accept edge.
- Full-width carry out: `a`=0xFFFF_FFFF_FFFF_FFFF, `b`=1, add → `result`=0, `cout`=1, `overflow`=0.
- Signed overflow on subtract: `a`=0x8000_0000_0000_0000, `b`=1, sub → `result`=0x7FFF_FFFF_FFFF_FFFF, `cout`=1, `overflow`=1. Also 5−7 → 0xFFFF_FFFF_FFFF_FFFE, `cout`=0.
- Busy rejection: `start` held high for 10 cycles with operands changing → exactly two `done` pulses, 6 cycles apart. Each result matches the operands present on its accept edge.
- Reset mid-operation: assert `rst_n`=0 in the second RUN cycle → all outputs at reset values immediately, `ready`=1, and no `done` pulse after release.
- Result hold: after `done`, idle for 20 cycles with `a`/`b` toggling → `result`, `cout` and `overflow` unchanged.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: slice width and the wide-add sequencer state encoding.
package alu_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/csa16.sv
// 16-bit carry-select adder slice: the upper byte is precomputed for both
// carry-in values and selected by the lower byte's carry.
module CSA16
  import alu_pkg::*;
(
  input  logic [SLICE_W-1:0] i_a,
  input  logic [SLICE_W-1:0] i_b,
  input  logic               i_cin,
  output logic [SLICE_W-1:0] o_sum,
  output logic               o_cout
);

  logic [8:0] w_lo;
  logic [8:0] w_hi0;
  logic [8:0] w_hi1;

  assign w_lo  = {1'b0, i_a[7:0]} + {1'b0, i_b[7:0]} + {8'd0, i_cin};
  assign w_hi0 = {1'b0, i_a[15:8]} + {1'b0, i_b[15:8]};
  assign w_hi1 = {1'b0, i_a[15:8]} + {1'b0, i_b[15:8]} + 9'd1;

  assign o_sum  = {(w_lo[8] ? w_hi1[7:0] : w_hi0[7:0]), w_lo[7:0]};
  assign o_cout = w_lo[8] ? w_hi1[8] : w_hi0[8];

endmodule

// File: rtl/csa_seq_adder.sv
// Wide add/subtract sequencer: one CSA16 slice per cycle, LSB first, with the
// inter-slice carry held in a register.
module csa_seq_adder
  import alu_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     op_sub,
  input  logic [SLICE_W*WORDS-1:0] a,
  input  logic [SLICE_W*WORDS-1:0] b,
  output logic                     ready,
  output logic                     done,
  output logic [SLICE_W*WORDS-1:0] result,
  output logic                     cout,
  output logic                     overflow
);

  localparam int W  = SLICE_W * WORDS;
  localparam int IW = $clog2(WORDS);

  seq_state_t r_state;
  seq_state_t w_state_nxt;

  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic               r_carry;
  logic [IW-1:0]      r_idx;
  logic [SLICE_W-1:0] w_a_sl;
  logic [SLICE_W-1:0] w_b_sl;
  logic [SLICE_W-1:0] w_sum;
  logic               w_cout;
  logic               w_last;
  logic               w_accept;

  assign w_accept = (r_state == IDLE) && start;
  assign w_last   = (r_idx == IW'(WORDS - 1));
  assign w_a_sl   = r_a[int'(r_idx) * SLICE_W +: SLICE_W];
  assign w_b_sl   = r_b[int'(r_idx) * SLICE_W +: SLICE_W];

  CSA16 u_csa16 (
    .i_a    (w_a_sl),
    .i_b    (w_b_sl),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  assign ready = (r_state == IDLE);
  assign done  = (r_state == DONE);

  // Operand registers carry no reset; they are only read in RUN after a load.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a <= a;
      r_b <= op_sub ? ~b : b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carry  <= 1'b0;
      r_idx    <= '0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (w_accept) begin
      r_carry  <= op_sub;
      r_idx    <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (r_state == RUN) begin
      result[int'(r_idx) * SLICE_W +: SLICE_W] <= w_sum;
      r_carry <= w_cout;
      // Index stops at the top slice rather than wrapping.
      if (w_last) begin
        cout     <= w_cout;
        overflow <= (w_a_sl[SLICE_W-1] == w_b_sl[SLICE_W-1]) &&
                    (w_sum[SLICE_W-1] != w_a_sl[SLICE_W-1]);
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

endmodule
